// File: rtl/div32x32_fast_if.sv
// Request/result bundle for the 32/32 unsigned divider.
// start/a/b come from the requester and are sampled only when the divider is idle;
// results hold until the next result load.
interface div32x32_fast_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/div32x32_fast.sv
// Restoring 32/32 unsigned divider. It skips up to three leading zero bytes
// of the dividend, then performs one restoring step per cycle.
module div32x32_fast (
  input  logic           clk,
  input  logic           reset,
  div32x32_fast_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic [32:0] rem_q;
  logic [5:0]  cnt_q;
  logic [1:0]  skp_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] quot_q;
  logic [31:0] remd_q;
  logic        dz_q;

  logic [32:0] t_d;
  logic [32:0] diff_d;
  logic [32:0] rem_d;
  logic        ge_d;
  logic [31:0] dvd_d;

  // One restoring step. rem_q[32] is always 0 after a step; if it were set,
  // t would certainly exceed the divisor.
  always_comb begin
    t_d    = {rem_q[31:0], dvd_q[31]};
    diff_d = t_d - {1'b0, dsr_q};
    ge_d   = rem_q[32] | (t_d >= {1'b0, dsr_q});
    rem_d  = ge_d ? diff_d : t_d;
    dvd_d  = {dvd_q[30:0], ge_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      skp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dvd_q  <= bus.a;
            dsr_q  <= bus.b;
            rem_q  <= '0;
            cnt_q  <= 6'd32;
            skp_q  <= 2'd0;
            busy_q <= 1'b1;
            if (bus.b == 32'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              quot_q  <= 32'hFFFF_FFFF;
              remd_q  <= bus.a;
              dz_q    <= 1'b1;
            end else begin
              state_q <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (dvd_q[31:24] == 8'd0 && skp_q != 2'd3) begin
            dvd_q <= {dvd_q[23:0], 8'h00};
            cnt_q <= cnt_q - 6'd8;
            skp_q <= skp_q + 2'd1;
          end else begin
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            quot_q  <= dvd_d;
            remd_q  <= rem_d[31:0];
            dz_q    <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dz_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_div32x32_fast.sv
// Directed bench for div32x32_fast: hand-computed vectors, busy/done timing,
// ignored restart, divide by zero and asynchronous reset mid-operation.
module tb_div32x32_fast;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  div32x32_fast_if bus();

  div32x32_fast dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one division and follows it until busy drops, stirring a/b meanwhile.
  // restart_at > 0 raises start again (a=9, b=3) during that busy cycle.
  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dz, input int exp_busy, input int restart_at);
    int nb;
    int nd;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nb = 0;
    nd = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      if (bus.done) nd++;
      if (restart_at != 0 && nb == restart_at) begin
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
      end else begin
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      tick();
    end
    bus.start = 1'b0;
    check_eq({tag, " busy_cycles"}, nb, exp_busy);
    check_eq({tag, " done_pulses"}, nd, 32'd1);
    check_eq({tag, " quotient"}, bus.quotient, exp_q);
    check_eq({tag, " remainder"}, bus.remainder, exp_r);
    check_eq({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dz});
  endtask

  initial begin
    int nb;
    int nd;
    n_checks  = 0;
    n_pass    = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b0;
    #1;
    check_eq("reset busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset done", {31'd0, bus.done}, 32'd0);
    check_eq("reset quotient", bus.quotient, 32'd0);
    check_eq("reset remainder", bus.remainder, 32'd0);
    check_eq("reset state", {30'd0, bus.dbg_state}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_div("100/7",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 13, 0);
    run_div("ffffffff/1", 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34, 0);
    run_div("10000/100",  32'h0001_0000,  32'h100,        32'h100,        32'd0,          1'b0, 27, 0);
    run_div("div0",       32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1,  0);
    run_div("restart",    32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0, 13, 4);
    run_div("deadbeef/16",32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 34, 0);
    run_div("1e6/1000",   32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0, 27, 0);
    run_div("0/5",        32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 13, 0);
    run_div("3/5",        32'd3,          32'd5,          32'd0,          32'd3,          1'b0, 13, 0);

    // Reset during busy cycle 10 of the ffffffff/1 case.
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nb = 0;
    while (bus.busy && nb < 10) begin
      nb++;
      if (nb < 10) tick();
    end
    check_eq("rst_mid reached", nb, 32'd10);
    reset = 1'b0;
    #1;
    check_eq("rst_mid busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_mid done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_mid quotient", bus.quotient, 32'd0);
    check_eq("rst_mid remainder", bus.remainder, 32'd0);
    check_eq("rst_mid div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done || bus.busy) nd++;
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done || bus.busy) nd++;
    end
    check_eq("rst_mid no_activity", nd, 32'd0);
    run_div("after_rst 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 13, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
